// File: rtl/anubis_key_reverser.sv
// Round-key store for Anubis: loads K0..KR in order, then serves K_r (encrypt) or K'_r (decrypt).
// Read latency is fixed at 2 cycles with one request per cycle; there is no backpressure and unserviceable requests return rd_err.
module anubis_key_reverser #(
    parameter int KEY_W    = 128,
    parameter int NUM_KEYS = 13,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic [KEY_W-1:0] wr_key,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_round,
    input  logic             dec_mode,
    output logic             full,
    output logic             rd_valid,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_err
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_READY
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    // GF(2^8) doubling, reduction polynomial 0x11D
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by H entry h[sel], with h = {01, 02, 04, 06}
    function automatic logic [7:0] mul_h(input logic [7:0] x, input logic [1:0] sel);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xtime(x);
        x4 = xtime(x2);
        case (sel)
            2'd0:    return x;
            2'd1:    return x2;
            2'd2:    return x4;
            default: return x4 ^ x2;
        endcase
    endfunction

    // Byte 4*i+j (MSB first) is row i, column j; b[i][j] = sum_k a[i][k] * h[k^j]
    function automatic logic [KEY_W-1:0] theta(input logic [KEY_W-1:0] a);
        logic [KEY_W-1:0] res;
        logic [7:0]       acc;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ mul_h(a[KEY_W-1-8*(4*i+k) -: 8], 2'(k ^ j));
                end
                res[KEY_W-1-8*(4*i+j) -: 8] = acc;
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             full_q, full_d;
    logic             mem_we;
    logic [KEY_W-1:0] mem_q [NUM_KEYS];

    logic             req_err;
    logic [IDX_W-1:0] rd_idx;

    logic             s1_vld_q, s1_vld_d;
    logic             s1_err_q, s1_err_d;
    logic             s1_theta_q, s1_theta_d;
    logic [KEY_W-1:0] s1_key_q, s1_key_d;

    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic [KEY_W-1:0] rd_key_q, rd_key_d;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        mem_we   = 1'b0;
        if (clear) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
        end else if (wr_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = IDX_W'(1);
                    state_d  = ST_LOAD;
                end
                ST_LOAD: begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end else begin
                        wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
        full_d = (state_d == ST_READY);
    end

    // Rejected requests never index the store, so an out-of-range round cannot address past it
    always_comb begin
        req_err = (state_q != ST_READY) || clear ||
                  ({1'b0, rd_round} >= (IDX_W+1)'(NUM_KEYS));
        rd_idx  = '0;
        if (!req_err) begin
            rd_idx = dec_mode ? (LAST_IDX - rd_round) : rd_round;
        end
        s1_vld_d   = rd_req;
        s1_err_d   = req_err;
        s1_theta_d = dec_mode && (rd_round != '0) && (rd_round != LAST_IDX);
        s1_key_d   = mem_q[rd_idx];
    end

    always_comb begin
        rd_valid_d = s1_vld_q;
        rd_err_d   = s1_vld_q && s1_err_q;
        rd_key_d   = '0;
        if (s1_vld_q && !s1_err_q) begin
            rd_key_d = s1_theta_q ? theta(s1_key_q) : s1_key_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_theta_q <= 1'b0;
            s1_key_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            s1_vld_q   <= s1_vld_d;
            s1_err_q   <= s1_err_d;
            s1_theta_q <= s1_theta_d;
            s1_key_q   <= s1_key_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_key_q   <= rd_key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[wr_ptr_q] <= wr_key;
        end
    end

    assign full     = full_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_key   = rd_key_q;

endmodule
